// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default widths for the PWM duty ramp controller.
// Imported by the period timer and by the ramp controller top.
package pwm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RAMP,
      ST_HOLD,
      ST_FAULT
   } ramp_state_t;

   localparam int DEF_DUTY_WIDTH = 8;
   localparam int DEF_DIV_WIDTH  = 16;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter with period_start pulse, wrap strobe and
// a periods-per-step divider that fires step_stb on the last wrap of a step.
module pwm_period_timer
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_clr,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 period_start,
   output logic                 wrap,
   output logic                 step_stb
);

   localparam logic [DUTY_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [DIV_WIDTH-1:0]  DIV_ONE = 1;

   logic [DUTY_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0]  div_cnt;
   logic                  div_last;

   assign wrap     = (cnt == {DUTY_WIDTH{1'b1}});
   assign div_last = (div_cnt == div - DIV_ONE);
   // A restart request wins over a coinciding wrap so a new command never steps early.
   assign step_stb = wrap & ~div_clr & div_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         period_start <= 1'b0;
         div_cnt      <= '0;
      end else begin
         cnt          <= cnt + CNT_ONE;
         period_start <= wrap;
         if (div_clr || (wrap && div_last))
            div_cnt <= '0;
         else if (wrap)
            div_cnt <= div_cnt + DIV_ONE;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer for edge_pwm: accepts target commands, slews duty
// at period boundaries, soft-stops on enable removal and zeroes on fault.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DUTY_WIDTH-1:0] tgt_duty,
   input  logic [DUTY_WIDTH-1:0] tgt_step,
   input  logic [DIV_WIDTH-1:0]  tgt_div,
   input  logic                  tgt_valid,
   output logic                  tgt_ready,
   input  logic                  fault,
   input  logic                  fault_clr,
   output logic [DUTY_WIDTH-1:0] duty,
   output logic                  period_start,
   output logic                  busy,
   output logic                  at_target
);

   localparam logic [DUTY_WIDTH-1:0] STEP_ONE = 1;
   localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = 1;

   ramp_state_t           state_q, state_d;
   logic [DUTY_WIDTH-1:0] duty_q, duty_d;
   logic [DUTY_WIDTH-1:0] tgt_q, tgt_d;
   logic [DUTY_WIDTH-1:0] step_q, step_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic                  stop_q, stop_d;
   logic                  accept, stop_now, wrap, step_stb;
   logic [DUTY_WIDTH-1:0] eff_tgt, stepped;

   // Move one step toward tgt in W+1 bits, clamping at tgt in either direction.
   function automatic logic [DUTY_WIDTH-1:0] step_toward(
      input logic [DUTY_WIDTH-1:0] cur,
      input logic [DUTY_WIDTH-1:0] tgt,
      input logic [DUTY_WIDTH-1:0] stp
   );
      logic [DUTY_WIDTH:0] c, t, s;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      s = {1'b0, stp};
      if (c < t)
         return (c + s >= t) ? tgt : cur + stp;
      else if (c > t)
         return (c < t + s) ? tgt : cur - stp;
      else
         return tgt;
   endfunction

   pwm_period_timer #(
      .DUTY_WIDTH(DUTY_WIDTH),
      .DIV_WIDTH (DIV_WIDTH)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .div_clr     (accept | (state_q != ST_RAMP)),
      .div         (div_q),
      .period_start(period_start),
      .wrap        (wrap),
      .step_stb    (step_stb)
   );

   assign stop_now = stop_q | ~enable;
   assign eff_tgt  = stop_now ? '0 : tgt_q;
   assign stepped  = step_toward(duty_q, eff_tgt, step_q);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      tgt_d   = tgt_q;
      step_d  = step_q;
      div_d   = div_q;
      stop_d  = stop_q;
      accept  = 1'b0;
      if (fault) begin
         state_d = ST_FAULT;
         duty_d  = '0;
         stop_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (!enable) begin
                  tgt_d = '0;
                  if (duty_q != '0) begin
                     stop_d  = 1'b1;
                     state_d = ST_RAMP;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (tgt_valid) begin
                  accept  = 1'b1;
                  tgt_d   = tgt_duty;
                  step_d  = (tgt_step == '0) ? STEP_ONE : tgt_step;
                  div_d   = (tgt_div == '0) ? DIV_ONE : tgt_div;
                  state_d = (tgt_duty != duty_q) ? ST_RAMP : ST_HOLD;
               end
            end
            ST_RAMP: begin
               if (!enable) begin
                  tgt_d  = '0;
                  stop_d = 1'b1;
               end
               if (step_stb) begin
                  duty_d = stepped;
                  if (stepped == eff_tgt) begin
                     state_d = stop_now ? ST_IDLE : ST_HOLD;
                     stop_d  = 1'b0;
                  end
               end
            end
            ST_FAULT: begin
               duty_d = '0;
               if (fault_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         step_q  <= STEP_ONE;
         div_q   <= DIV_ONE;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         step_q  <= step_d;
         div_q   <= div_d;
         stop_q  <= stop_d;
      end
   end

   assign duty      = duty_q;
   assign busy      = (state_q == ST_RAMP);
   assign at_target = (state_q == ST_HOLD);
   assign tgt_ready = rst & enable & ((state_q == ST_IDLE) | (state_q == ST_HOLD));

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer that drives the `duty` input of the team's `edge_pwm` block. It accepts target duty commands over a valid/ready handshake. It slews the applied duty toward the target by a programmable step every N PWM periods, changing duty only at period boundaries. It also handles soft stop on enable removal and immediate zeroing on fault. It sits between the software/register interface and `edge_pwm`.

Parameters:
- DUTY_WIDTH, 8, width of duty and of the PWM period counter; PWM period = 2^DUTY_WIDTH clk cycles.
- DIV_WIDTH, 16, width of periods-per-step divider.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- enable  input  1  run request; low = soft stop (ramp to 0).
- tgt_duty  input  DUTY_WIDTH  commanded target duty.
- tgt_step  input  DUTY_WIDTH  duty increment per step; 0 treated as 1.
- tgt_div  input  DIV_WIDTH  PWM periods per step; 0 treated as 1.
- tgt_valid  input  1  command valid.
- tgt_ready  output  1  command accept (combinational from state and enable).
- fault  input  1  synchronous fault; forces duty 0.
- fault_clr  input  1  clears latched fault.
- duty  output  DUTY_WIDTH  registered duty to `edge_pwm`.
- period_start  output  1  registered one-cycle pulse at period-counter value 0.
- busy  output  1  high in RAMP.
- at_target  output  1  high in HOLD.

Behaviour:
- Reset (rst=0, async): duty=0, state=IDLE, period counter=0, divider=0, period_start=0, busy=0, at_target=0, latched fault=0. tgt_ready=0 while in reset.
- Period counter: free-running DUTY_WIDTH bits, wraps 2^W-1→0. The wrap cycle is the cycle with count == 2^W-1. period_start=1 in the cycle the count is 0.
- States:
  - IDLE: duty=0, tgt_ready=enable.
  - RAMP: busy=1, tgt_ready=0.
  - HOLD: at_target=1, tgt_ready=enable.
  - FAULT: duty=0, tgt_ready=0.
- Accept (tgt_valid & tgt_ready):
  - Latch target, step, div.
  - Go to RAMP if target != duty, else go to HOLD.
  - Divider restarts at 0.
- RAMP step timing:
  - The divider increments on each wrap cycle.
  - When the divider reaches div-1 (on a wrap cycle), the divider clears and duty steps toward target by step. The new duty is therefore visible from the first cycle of the next period.
- Step arithmetic:
  - Compute in DUTY_WIDTH+1 bits and saturate at target; no overshoot, no wrap, no underflow.
  - When the updated duty == target, go to HOLD.
- Enable low in IDLE/HOLD/RAMP:
  - Internal target forced to 0, using the latched step/div (step=1, div=1 if no command was ever accepted).
  - Enter RAMP if duty != 0; on reaching 0 go to IDLE.
  - Enable high again mid soft-stop: the ramp continues to 0, then IDLE.
- Fault:
  - fault=1 in any state: the next clock gives duty=0 (not period-aligned) and state=FAULT; fault is latched.
  - FAULT→IDLE only on fault_clr=1 with fault=0; fault_clr while fault=1 is ignored.
- Priority: fault > enable low > command accept.
- Simultaneous tgt_valid and enable falling: tgt_ready is already 0, so no accept.

Decomposition:
- Package `pwm_ctrl_pkg`: state enum (IDLE, RAMP, HOLD, FAULT) and the default DUTY_WIDTH/DIV_WIDTH constants.
- Sub-module `pwm_period_timer`: period counter, period_start, wrap strobe and divider with clear/step-strobe outputs.
- The FSM and saturating step logic stay in `pwm_ramp_ctrl`.

Test Plan:
1. Reset release, enable=1; send tgt 64, step 16, div 1 → duty 16, 32, 48, 64 at the first four period boundaries (cycles 256, 512, 768, 1024 after release); at_target=1 after the fourth; tgt_ready=1.
2. From 0, send tgt 25, step 10, div 3 → duty 10, 20, 25, one update every 3 periods (768 clk); never 30.
3. In HOLD at 200, send tgt 0, step 255 → duty 0 at the next boundary; no wrap to a high value; HOLD.
4. Fault=1 mid-ramp at duty 48 → duty 0 on the next clk, busy=0, tgt_ready=0. fault_clr while fault=1 → stays FAULT. fault=0 then fault_clr → IDLE, duty 0.
5. HOLD at 128, step 32, div 1; drop enable → duty 96, 64, 32, 0 on successive boundaries, then IDLE. tgt_valid during this is not accepted.
6. Assert rst=0 mid-ramp between clock edges → duty, busy, at_target and period_start go to 0 immediately. After release, tgt_ready=0 until enable=1.
